// File: rtl/row_pkg.sv
// Shared constants and output-state encoding for the row deserializer.
package row_pkg;

    localparam int ROW_WIDTH = 64;
    localparam int ROW_IDX_W = 6;

    typedef enum logic {
        O_EMPTY = 1'b0,
        O_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/row_deserializer64_mod_counter.sv
// Modulo-N counter with synchronous clear; wrap flags the enabled step from N-1 back to 0.
import row_pkg::*;

module mod_counter #(
    parameter int N = ROW_WIDTH,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign wrap = en && (value == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= wrap ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/row_deserializer64.sv
// MSB-first serial-to-parallel row assembler with a one-row output holding register.
module row_deserializer64
    import row_pkg::*;
#(
    parameter int WIDTH = ROW_WIDTH,
    parameter int IDX_W = ROW_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             flush,
    output logic [IDX_W-1:0] bit_index,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

    logic [WIDTH-1:0] coll;
    logic [WIDTH-1:0] row_next;
    logic [IDX_W-1:0] wr_pos;
    logic             accept;
    logic             complete;
    out_state_t       state;
    out_state_t       state_next;

    assign word_valid = (state == O_FULL);

    // Only the final bit of a row has to wait for the output register to free up.
    assign bit_ready = !flush && !((bit_index == LAST) && word_valid && !word_ready);
    assign accept    = bit_valid && bit_ready;

    mod_counter #(.N(WIDTH), .W(IDX_W)) u_index (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .clr   (flush),
        .value (bit_index),
        .wrap  (complete)
    );

    // The row including the bit being accepted now, so completion needs no extra cycle.
    always_comb begin
        wr_pos           = LAST - bit_index;
        row_next         = coll;
        row_next[wr_pos] = bit_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll <= '0;
        end else if (accept) begin
            coll <= row_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_out <= '0;
        end else if (complete) begin
            word_out <= row_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= O_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            O_EMPTY: if (complete) state_next = O_FULL;
            O_FULL:  if (word_ready && !complete) state_next = O_EMPTY;
            default: state_next = O_EMPTY;
        endcase
    end

endmodule

// File: tb/tb_row_deserializer64.sv
// Directed and scoreboard-checked bench for row_deserializer64.
module tb_row_deserializer64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bit_in;
    logic        bit_valid;
    logic        flush;
    logic        word_ready;
    logic        bit_ready;
    logic        word_valid;
    logic [5:0]  bit_index;
    logic [63:0] word_out;

    int checks = 0;
    int passes = 0;

    localparam int ROWS = 300;

    row_deserializer64 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .flush      (flush),
        .bit_index  (bit_index),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change on the falling edge; combinational outputs are sampled 1 ns later.
    task automatic applyStimulus(input logic v, input logic b, input logic wr, input logic fl);
        @(negedge clk);
        bit_valid  = v;
        bit_in     = b;
        word_ready = wr;
        flush      = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendRow(input logic [63:0] row, input int nbits, input logic wr);
        for (int k = 0; k < nbits; k++) begin
            applyStimulus(1'b1, row[63-k], wr, 1'b0);
        end
    endtask

    logic [63:0] pat, row5, sweep, row_a, row_b, p4, ones, row_c;
    logic [63:0] cur_row, m_word;
    int          m_idx, sent, consumed, cycles;
    logic        m_valid, bv, wr, exp_ready, consume, completed;

    initial begin
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b0;
        rst_n      = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset word_valid", word_valid, 0);
        checkOutput("reset word_out", word_out, 0);
        checkOutput("reset bit_index", bit_index, 0);
        checkOutput("reset bit_ready", bit_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] back-to-back row");
        pat = 64'hA5A5_0000_FFFF_1234;
        sendRow(pat, 64, 1'b1);
        checkOutput("t1 valid before final edge", word_valid, 0);
        checkOutput("t1 index at final bit", bit_index, 63);
        tick();
        checkOutput("t1 word_valid", word_valid, 1);
        checkOutput("t1 word_out", word_out, pat);
        checkOutput("t1 bit_index wrap", bit_index, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("t1 drained", word_valid, 0);

        $display("[TB] single-one rows");
        row5 = 64'h0400_0000_0000_0000;
        sendRow(row5, 64, 1'b1);
        tick();
        checkOutput("t2 k=5 word", word_out, 64'h0400_0000_0000_0000);
        for (int k = 0; k < 64; k++) begin
            sweep = 64'd1 << (63 - k);
            sendRow(sweep, 64, 1'b1);
            tick();
            checkOutput("t2 sweep word", word_out, sweep);
            checkOutput("t2 select round trip", word_out[63-k], 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        $display("[TB] output backpressure");
        row_a = 64'hDEAD_BEEF_0123_4567;
        row_b = 64'h1357_9BDF_2468_ACE0;
        sendRow(row_a, 64, 1'b0);
        tick();
        checkOutput("t3 A valid", word_valid, 1);
        checkOutput("t3 A word", word_out, row_a);
        sendRow(row_b, 63, 1'b0);
        applyStimulus(1'b1, row_b[0], 1'b0, 1'b0);
        checkOutput("t3 index at B final", bit_index, 63);
        checkOutput("t3 B final stalled", bit_ready, 0);
        checkOutput("t3 A held", word_out, row_a);
        tick();
        checkOutput("t3 A still held", word_out, row_a);
        checkOutput("t3 valid held", word_valid, 1);
        checkOutput("t3 index held", bit_index, 63);
        applyStimulus(1'b1, row_b[0], 1'b1, 1'b0);
        checkOutput("t3 ready released", bit_ready, 1);
        tick();
        checkOutput("t3 B loaded", word_out, row_b);
        checkOutput("t3 no bubble", word_valid, 1);
        checkOutput("t3 index wrap", bit_index, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("t3 drained", word_valid, 0);

        $display("[TB] flush");
        p4   = 64'h0F0F_3C3C_5A5A_9669;
        ones = 64'hFFFF_FFFF_FFFF_FFFF;
        sendRow(p4, 20, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("t4 index before flush", bit_index, 20);
        checkOutput("t4 flush blocks bit", bit_ready, 0);
        tick();
        checkOutput("t4 index cleared", bit_index, 0);
        sendRow(ones, 64, 1'b0);
        tick();
        checkOutput("t4 ones word", word_out, ones);
        checkOutput("t4 ones valid", word_valid, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("t4 flush keeps valid", word_valid, 1);
        checkOutput("t4 flush keeps word", word_out, ones);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("t4 flush drains", word_valid, 0);

        $display("[TB] async reset");
        row_c = 64'h0123_4567_89AB_CDEF;
        sendRow(row_c, 64, 1'b0);
        tick();
        checkOutput("t5 C valid", word_valid, 1);
        sendRow(p4, 40, 1'b0);
        tick();
        checkOutput("t5 mid-row index", bit_index, 40);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5 reset valid", word_valid, 0);
        checkOutput("t5 reset word", word_out, 0);
        checkOutput("t5 reset index", bit_index, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        checkOutput("t5 ready after reset", bit_ready, 1);

        $display("[TB] random throttling");
        m_idx    = 0;
        m_valid  = 1'b0;
        m_word   = '0;
        sent     = 0;
        consumed = 0;
        cycles   = 0;
        cur_row  = {$urandom(), $urandom()};
        while (consumed < ROWS && cycles < 60000) begin
            bv = (sent < ROWS) && ($urandom_range(0, 9) < 8);
            wr = ($urandom_range(0, 3) != 0);
            applyStimulus(bv, cur_row[63-m_idx], wr, 1'b0);
            exp_ready = !((m_idx == 63) && m_valid && !wr);
            checkOutput("t6 handshake", {bit_ready, word_valid, bit_index},
                        {exp_ready, m_valid, 6'(m_idx)});
            if (m_valid) checkOutput("t6 word", word_out, m_word);
            consume   = m_valid && wr;
            completed = 1'b0;
            if (consume) consumed++;
            if (bv && exp_ready) begin
                if (m_idx == 63) begin
                    m_word    = cur_row;
                    m_valid   = 1'b1;
                    m_idx     = 0;
                    completed = 1'b1;
                    sent++;
                    cur_row   = {$urandom(), $urandom()};
                end else begin
                    m_idx++;
                end
            end
            if (consume && !completed) m_valid = 1'b0;
            cycles++;
        end
        checkOutput("t6 rows consumed", 64'(consumed), 64'(ROWS));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
